// File: rtl/seven_seg_scanner_if.sv
// Display bus between the scan source/digit producer and seven_seg_scanner.
//   scan_clk  : slow square wave; each rising edge advances one digit
//   digits    : four 4-bit digit codes, [3:0] = rightmost digit
//   dp_mask   : decimal-point enables, 1 = lit
//   anode     : digit enables, active-low
//   seg       : segments {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point, active-low
// master drives scan_clk/digits/dp_mask; slave (the scanner) drives anode/seg/dp.
interface seven_seg_scanner_if;
  logic        scan_clk;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output scan_clk, digits, dp_mask,
    input  anode, seg, dp
  );

  modport slave (
    input  scan_clk, digits, dp_mask,
    output anode, seg, dp
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes four 7-segment digits.
// scan_clk is sampled as data, synchronised and edge-detected in the clk domain. Digit codes and
// decimal-point mask are snapshotted once per frame (at the idx 3 -> 0 wrap) so a frame never
// mixes old and new values. All display outputs are registered.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : seven_seg_scanner_if.slave (scan_clk, digits, dp_mask in; anode, seg, dp out)
// Parameter BLANK_CYCLES (1..255): all-off cycles after each digit advance.
// Optional feature macro SCAN_BLANK_EN: inserts the BLANK state (inter-digit blanking).
// Without it the BLANK state and counter are absent and BLANK_CYCLES is ignored.
module seven_seg_scanner #(
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  seven_seg_scanner_if.slave bus
);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank_cycles
    $error("BLANK_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

`ifdef SCAN_BLANK_EN
  localparam state_e      StAfterAdv = StBlank;
  localparam logic [7:0]  BlankLast  = 8'(BLANK_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  localparam state_e      StAfterAdv = StShow;
`endif

  logic        sync1_q, sync2_q, prev_q;
  logic        adv;
  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] snap_dig_q, snap_dig_d;
  logic [3:0]  snap_dp_q, snap_dp_d;
  logic [3:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  function automatic logic [6:0] decode(input logic [3:0] code);
    unique case (code)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0111111; // minus sign
      default: return 7'h7F;
    endcase
  endfunction

  // One-clk pulse on the synchronised rising edge of scan_clk.
  assign adv = sync2_q & ~prev_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
`ifdef SCAN_BLANK_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (adv) begin
          idx_d      = 2'd0;
          snap_dig_d = bus.digits;
          snap_dp_d  = bus.dp_mask;
          state_d    = StAfterAdv;
`ifdef SCAN_BLANK_EN
          cnt_d      = 8'd0;
`endif
        end
      end
      StShow: begin
        if (adv) begin
          idx_d = idx_q + 2'd1;
          // Frame boundary: take the new values only when wrapping back to digit 0.
          if (idx_q == 2'd3) begin
            snap_dig_d = bus.digits;
            snap_dp_d  = bus.dp_mask;
          end
          state_d = StAfterAdv;
`ifdef SCAN_BLANK_EN
          cnt_d   = 8'd0;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      StBlank: begin
        // adv is deliberately ignored here: no idx change, counter keeps running.
        if (cnt_q == BlankLast) state_d = StShow;
        else                    cnt_d   = cnt_q + 8'd1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs follow the current state/idx/snapshot and are registered, so only one anode can be
  // low in any cycle.
  always_comb begin
    anode_d = 4'b1111;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (state_q == StShow) begin
      anode_d = ~(4'b0001 << idx_q);
      seg_d   = decode(snap_dig_q[{idx_q, 2'b00} +: 4]);
      dp_d    = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      snap_dig_q <= 16'hFFFF;
      snap_dp_q  <= 4'b0000;
`ifdef SCAN_BLANK_EN
      cnt_q      <= 8'd0;
`endif
      anode_q    <= 4'b1111;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      sync1_q    <= bus.scan_clk;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
`ifdef SCAN_BLANK_EN
      cnt_q      <= cnt_d;
`endif
      anode_q    <= anode_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.anode = anode_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner. scan_clk is a 40-clk square wave; each rising edge
// pushes the expected display (anode/seg/dp and the cycle it must appear) onto a scoreboard,
// which a negedge monitor pops and compares. The monitor also checks that at most one anode is
// low in every cycle. Build with and without +define+SCAN_BLANK_EN.
module tb_seven_seg_scanner;

  localparam int unsigned B = 16;
`ifdef SCAN_BLANK_EN
  localparam int unsigned LAT = 4 + B;
`else
  localparam int unsigned LAT = 4;
`endif

  typedef struct {
    int unsigned due;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int          n_checks;
  int          n_fail;
  exp_t        q[$];

  // Reference of the spec-level display state.
  logic        m_active;
  logic [1:0]  m_idx;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;

  seven_seg_scanner_if bus ();

  seven_seg_scanner #(
    .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0111111;
      default: return 7'h7F;
    endcase
  endfunction

  // Advance the reference on a scan_clk rise at cycle k and queue the expected display.
  function automatic void push_adv(input int unsigned k);
    exp_t e;
    if (!m_active) begin
      m_active = 1'b1;
      m_idx    = 2'd0;
      m_dig    = bus.digits;
      m_dp     = bus.dp_mask;
    end else begin
      m_idx = m_idx + 2'd1;
      if (m_idx == 2'd0) begin
        m_dig = bus.digits;
        m_dp  = bus.dp_mask;
      end
    end
    e.due   = k + LAT;
    e.anode = ~(4'b0001 << m_idx);
    e.seg   = dec(m_dig[{m_idx, 2'b00} +: 4]);
    e.dp    = ~m_dp[m_idx];
    q.push_back(e);
  endfunction

  // Scoreboard monitor plus the every-cycle one-hot anode check.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      n_checks++;
      if ($countones(~bus.anode) > 1) begin
        n_fail++;
        $display("FAIL anode_onehot cyc %0d: anode=%b, at most one bit may be low", cyc,
                 bus.anode);
      end
      if (q.size() > 0 && cyc >= q[0].due) begin
        e = q.pop_front();
        n_checks += 3;
        if (bus.anode !== e.anode) begin
          n_fail++;
          $display("FAIL sb_anode cyc %0d: got %b want %b", cyc, bus.anode, e.anode);
        end
        if (bus.seg !== e.seg) begin
          n_fail++;
          $display("FAIL sb_seg cyc %0d: got %b want %b", cyc, bus.seg, e.seg);
        end
        if (bus.dp !== e.dp) begin
          n_fail++;
          $display("FAIL sb_dp cyc %0d: got %b want %b", cyc, bus.dp, e.dp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst      = 1'b1;
    m_active = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  // One full 40-clk scan_clk period starting with a rise.
  task automatic adv_pulse();
    int unsigned k;
    tick();
    bus.scan_clk = 1'b1;
    k = cyc;
    push_adv(k);
    while (cyc < k + 20) tick();
    bus.scan_clk = 1'b0;
    while (cyc < k + 39) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_checks += 3;
    if (bus.anode !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_anode: got %b want 1111", bus.anode);
    end
    if (bus.seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_seg: got %b want 1111111", bus.seg);
    end
    if (bus.dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dp: got %b want 1", bus.dp);
    end
    tick();
    rst = 1'b0;
    bus.digits  = 16'h4321;
    bus.dp_mask = 4'b0001;
    repeat (2) adv_pulse();
    // Now showing digit1; assert reset between edges.
    tick();
    #2 rst = 1'b1;
    m_active = 1'b0;
    #1;
    n_checks += 3;
    if (bus.anode !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_mid_anode: got %b want 1111", bus.anode);
    end
    if (bus.seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_mid_seg: got %b want 1111111", bus.seg);
    end
    if (bus.dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_dp: got %b want 1", bus.dp);
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.anode !== 4'b1111) begin
        n_fail++;
        $display("FAIL reset_stay_off: got %b want 1111", bus.anode);
      end
    end
    adv_pulse();
  endtask

  task automatic test_pattern();
    do_reset();
    bus.digits  = 16'h1A08;
    bus.dp_mask = 4'b0100;
    repeat (5) adv_pulse();
  endtask

  task automatic test_blank_codes();
    do_reset();
    bus.digits  = 16'hFBC9;
    bus.dp_mask = 4'b0000;
    repeat (4) adv_pulse();
  endtask

  task automatic test_mid_frame();
    do_reset();
    bus.digits  = 16'h1234;
    bus.dp_mask = 4'b1000;
    repeat (2) adv_pulse();
    bus.digits  = 16'h5678;
    bus.dp_mask = 4'b0001;
    repeat (4) adv_pulse();
  endtask

  // Exact latency: rise after edge k -> new digit visible at edge k+LAT, blank window before it.
  task automatic test_timing();
    int unsigned k;
    int          off;
    do_reset();
    bus.digits  = 16'h0765;
    bus.dp_mask = 4'b0010;
    adv_pulse();
    tick();
    bus.scan_clk = 1'b1;
    k = cyc;
    push_adv(k);
    off = 0;
    while (cyc < k + LAT) begin
      @(negedge clk);
      if (cyc == k + 3) begin
        n_checks++;
        if (bus.anode !== 4'b1110) begin
          n_fail++;
          $display("FAIL timing_old_digit: got %b want 1110", bus.anode);
        end
      end
      if (cyc >= k + 4 && cyc < k + LAT && bus.anode === 4'b1111) off++;
    end
    n_checks++;
    if (off != int'(LAT - 4)) begin
      n_fail++;
      $display("FAIL timing_blank_len: got %0d want %0d", off, LAT - 4);
    end
    while (cyc < k + 20) tick();
    bus.scan_clk = 1'b0;
    while (cyc < k + 39) tick();
    adv_pulse();
  endtask

`ifdef SCAN_BLANK_EN
  task automatic test_blank_drop();
    int unsigned k;
    do_reset();
    bus.digits  = 16'h3210;
    bus.dp_mask = 4'b0000;
    adv_pulse();
    tick();
    bus.scan_clk = 1'b1;
    k = cyc;
    push_adv(k);
    while (cyc < k + 2) tick();
    bus.scan_clk = 1'b0;
    while (cyc < k + 5) tick();
    bus.scan_clk = 1'b1;  // this rise lands inside BLANK and must be dropped
    while (cyc < k + 7) tick();
    bus.scan_clk = 1'b0;
    while (cyc < k + 35) tick();
    @(negedge clk);
    n_checks++;
    if (bus.anode !== 4'b1101) begin
      n_fail++;
      $display("FAIL blank_drop_idx: got %b want 1101", bus.anode);
    end
    while (cyc < k + 39) tick();
    adv_pulse();
  endtask
`endif

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    m_active     = 1'b0;
    m_idx        = 2'd0;
    m_dig        = 16'hFFFF;
    m_dp         = 4'b0000;
    rst          = 1'b1;
    bus.scan_clk = 1'b0;
    bus.digits   = 16'h0000;
    bus.dp_mask  = 4'b0000;
    test_reset();
    test_pattern();
    test_blank_codes();
    test_mid_frame();
    test_timing();
`ifdef SCAN_BLANK_EN
    test_blank_drop();
`endif
    repeat (LAT + 2) tick();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
